// File: rtl/qspi_mem_emu_pkg.sv
// qspi_mem_emu_pkg: FSM states and QPI protocol constants for qspi_mem_emu
package qspi_mem_emu_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE} state_t;
    localparam logic [7:0] CMD_READ = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam int ADDR_NIBBLES = 6;
    localparam int CMD_NIBBLES = 2;
endpackage

// File: rtl/qspi_mem_emu_sync.sv
// qspi_mem_emu_sync: 2-flop synchronizers for cs/sck/sdio plus SCK rise/fall strobes
module qspi_mem_emu_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_raw,
    input  logic       sck_raw,
    input  logic [3:0] sdio_raw,
    output logic       cs_n,
    output logic       rise,
    output logic       fall,
    output logic [3:0] sdio
);
    logic [1:0] cs_q;
    logic [2:0] sck_q;
    logic [3:0] sd1_q, sd2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= 2'b11;
            sck_q <= '0;
            sd1_q <= '0;
            sd2_q <= '0;
        end else begin
            cs_q <= {cs_q[0], cs_raw};
            sck_q <= {sck_q[1:0], sck_raw};
            sd1_q <= sdio_raw;
            sd2_q <= sd1_q;
        end
    end
    assign cs_n = cs_q[1];
    assign rise = sck_q[1] & ~sck_q[2];
    assign fall = ~sck_q[1] & sck_q[2];
    assign sdio = sd2_q;
endmodule

// File: rtl/qspi_mem_emu.sv
// qspi_mem_emu: QPI mode-0 slave serving block RAM; define QSPI_MEM_EMU_WRITE_EN to decode 0x38 writes
module qspi_mem_emu
    import qspi_mem_emu_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW = $clog2(DEPTH),
    parameter int DUMMY_CYC = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs_in,
    input  logic          sck_i,
    input  logic [3:0]    sdio_i,
    output logic [3:0]    sdio_o,
    output logic [3:0]    sdio_oe_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [7:0]    ld_data_i
);
    localparam logic [7:0] CMD_LAST = 8'(CMD_NIBBLES - 1);
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_NIBBLES - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

    state_t state_q, state_d;
    logic cs_n, rise, fall, cnt_done, cmd_ok;
    logic [3:0] nib, sdio_q;
    logic [7:0] cnt_q, byte_q, mem_q, mem_din;
    logic [AW-5:0] sh_q;
    logic [AW-1:0] sh_next, addr_q, mem_addr;
    logic oe_q, lo_q, rd_pend_q, rvld_q, rd_go, wr_go, mem_we;
    logic [7:0] mem [DEPTH];

    qspi_mem_emu_sync u_sync (
        .clk(clk_i), .rst(rst_i), .cs_raw(cs_in), .sck_raw(sck_i), .sdio_raw(sdio_i),
        .cs_n(cs_n), .rise(rise), .fall(fall), .sdio(nib)
    );

    // only the low AW address bits are kept, so higher address nibbles alias
    assign sh_next = {sh_q, nib};
    assign cnt_done = rise && cnt_q == (state_q == CMD ? CMD_LAST : state_q == ADDR ? ADDR_LAST : DUMMY_LAST);

`ifdef QSPI_MEM_EMU_WRITE_EN
    logic wr_cmd_q, wr_pend_q;
    logic [3:0] wbuf_q;
    logic [7:0] wdata_q;
    assign cmd_ok = sh_next[7:0] == CMD_READ || sh_next[7:0] == CMD_WRITE;
    assign wr_go = wr_pend_q & ~ld_we_i;
    assign mem_din = ld_we_i ? ld_data_i : wdata_q;
`else
    assign cmd_ok = sh_next[7:0] == CMD_READ;
    assign wr_go = 1'b0;
    assign mem_din = ld_data_i;
`endif
    assign rd_go = rd_pend_q & ~ld_we_i & ~wr_go;
    assign mem_we = ld_we_i | wr_go;
    assign mem_addr = ld_we_i ? ld_addr_i : addr_q;
    assign sdio_o = sdio_q;
    assign sdio_oe_o = {4{oe_q}};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = CMD;
            CMD:     state_d = cnt_done ? (cmd_ok ? ADDR : IGNORE) : CMD;
`ifdef QSPI_MEM_EMU_WRITE_EN
            ADDR:    state_d = cnt_done ? (wr_cmd_q ? WR : DUMMY) : ADDR;
`else
            ADDR:    state_d = cnt_done ? DUMMY : ADDR;
`endif
            DUMMY:   state_d = cnt_done ? RD : DUMMY;
            default: state_d = state_q;
        endcase
        if (cs_n) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sh_q <= '0;
            addr_q <= '0;
            oe_q <= 1'b0;
            lo_q <= 1'b0;
            sdio_q <= '0;
            rd_pend_q <= 1'b0;
            rvld_q <= 1'b0;
            byte_q <= '0;
`ifdef QSPI_MEM_EMU_WRITE_EN
            wr_cmd_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wbuf_q <= '0;
            wdata_q <= '0;
`endif
        end else begin
            cnt_q <= state_d != state_q ? '0 : cnt_q + {7'd0, rise};
            if (rise) sh_q <= sh_next[AW-5:0];
            rvld_q <= rd_go;
            if (rd_go) rd_pend_q <= 1'b0;
            if (rvld_q) byte_q <= mem_q;
            if (state_q == ADDR && cnt_done) begin
                addr_q <= sh_next;
                rd_pend_q <= state_d == DUMMY;
            end
            if (state_d != state_q) lo_q <= 1'b0;
            else if (state_q == RD && fall) begin
                oe_q <= 1'b1;
                sdio_q <= lo_q ? byte_q[3:0] : byte_q[7:4];
                lo_q <= ~lo_q;
                // next byte is prefetched a full SCK period before its high nibble is due
                if (lo_q) begin
                    addr_q <= addr_q + AW'(1);
                    rd_pend_q <= 1'b1;
                end
            end
            if (state_d != RD) begin
                oe_q <= 1'b0;
                sdio_q <= '0;
            end
`ifdef QSPI_MEM_EMU_WRITE_EN
            if (state_q == CMD && cnt_done) wr_cmd_q <= sh_next[7:0] == CMD_WRITE;
            if (wr_go) begin
                wr_pend_q <= 1'b0;
                addr_q <= addr_q + AW'(1);
            end
            if (state_q == WR && rise && !cs_n) begin
                lo_q <= ~lo_q;
                if (lo_q) begin
                    wdata_q <= {wbuf_q, nib};
                    wr_pend_q <= 1'b1;
                end else wbuf_q <= nib;
            end
`endif
        end
    end

    // backdoor port wins; deferred QSPI accesses retry from their pending flags
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_q <= mem[mem_addr];
    end
endmodule

// File: tb/tb_qspi_mem_emu.sv
// tb_qspi_mem_emu: directed QPI reads/writes/aborts checked against a byte-array model of the memory
module tb_qspi_mem_emu;
    localparam int DEPTH = 16384;
    localparam int AW = 14;
    localparam int DUMMY_CYC = 4;
    localparam int H = 5;

    logic clk = 1'b0, rst_i = 1'b1, cs_in = 1'b1, sck_i = 1'b0, ld_we_i = 1'b0;
    logic [3:0] sdio_i = '0, sdio_o, sdio_oe_o;
    logic [AW-1:0] ld_addr_i = '0;
    logic [7:0] ld_data_i = '0;
    logic [7:0] model [DEPTH];
    int checks = 0, failures = 0;
    logic chk_en = 1'b0;
    logic [3:0] exp_oe = '0, exp_nib = '0;

    qspi_mem_emu #(.DEPTH(DEPTH), .DUMMY_CYC(DUMMY_CYC)) dut (
        .clk_i(clk), .rst_i(rst_i), .cs_in(cs_in), .sck_i(sck_i), .sdio_i(sdio_i),
        .sdio_o(sdio_o), .sdio_oe_o(sdio_oe_o),
        .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (sdio_oe_o !== exp_oe || (exp_oe != 4'h0 && sdio_o !== exp_nib)) begin
                failures++;
                $display("FAIL pins t=%0t oe=%h sdio=%h required oe=%h sdio=%h", $time, sdio_oe_o, sdio_o, exp_oe, exp_nib);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic load(input int a, input logic [7:0] d);
        ld_we_i = 1'b1;
        ld_addr_i = AW'(a);
        ld_data_i = d;
        tick(1);
        ld_we_i = 1'b0;
        model[a] = d;
    endtask

    task automatic nib(input logic [3:0] n);
        sdio_i = n;
        tick(H);
        sck_i = 1'b1;
        tick(H);
        sck_i = 1'b0;
    endtask

    task automatic header(input logic [7:0] cmd, input logic [23:0] a);
        cs_in = 1'b0;
        tick(4);
        nib(cmd[7:4]);
        nib(cmd[3:0]);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    task automatic finish_cs;
        chk_en = 1'b0;
        cs_in = 1'b1;
        tick(3);
        check("oe_release", 32'(sdio_oe_o), 32'h0);
        exp_oe = 4'h0;
        chk_en = 1'b1;
        tick(4);
    endtask

    task automatic qspi_read(input logic [23:0] a, input int nn, output logic [31:0] got);
        logic [7:0] b;
        got = '0;
        header(8'hEB, a);
        for (int i = 0; i < DUMMY_CYC; i++) nib(4'h0);
        chk_en = 1'b0;
        for (int k = 0; k < nn; k++) begin
            b = model[(int'(a) + k / 2) % DEPTH];
            tick(4);
            exp_nib = (k % 2 == 1) ? b[3:0] : b[7:4];
            exp_oe = 4'hF;
            chk_en = 1'b1;
            got = {got[27:0], sdio_o};
            if (k < nn - 1) begin
                tick(1);
                sck_i = 1'b1;
                tick(H);
                chk_en = 1'b0;
                sck_i = 1'b0;
            end
        end
        chk_en = 1'b0;
    endtask

    task automatic qspi_write(input logic [23:0] a, input logic [19:0] d, input int n);
        header(8'h38, a);
        for (int i = 0; i < n; i++) nib(d[(n-1-i)*4 +: 4]);
`ifdef QSPI_MEM_EMU_WRITE_EN
        for (int i = 0; i < n / 2; i++) model[(int'(a[AW-1:0]) + i) % DEPTH] = d[(n-2-2*i)*4 +: 8];
`endif
        tick(2);
        finish_cs;
    endtask

    task automatic reset_pulse;
        chk_en = 1'b0;
        rst_i = 1'b1;
        cs_in = 1'b1;
        ld_we_i = 1'b1;
        ld_addr_i = AW'(256);
        ld_data_i = 8'h9D;
        tick(1);
        check("oe_in_reset", 32'(sdio_oe_o), 32'h0);
        ld_we_i = 1'b0;
        model[256] = 8'h9D;
        tick(2);
        rst_i = 1'b0;
        tick(4);
        exp_oe = 4'h0;
        chk_en = 1'b1;
    endtask

    initial begin
        logic [31:0] got;
        tick(3);
        check("reset_oe", 32'(sdio_oe_o), 32'h0);
        check("reset_sdio", 32'(sdio_o), 32'h0);
        rst_i = 1'b0;
        tick(2);
        exp_oe = 4'h0;
        chk_en = 1'b1;
        load(0, 8'hA5);
        load(1, 8'h3C);
        load(2, 8'h47);
        load(DEPTH - 1, 8'h7E);
        load(16, 8'hC0);
        load(17, 8'hDE);
        load(18, 8'h5A);
        qspi_read(24'h000000, 4, got);
        finish_cs;
        check("read_a53c", got, 32'hA53C);
        load(0, 8'h11);
        qspi_read(24'h003FFF, 4, got);
        finish_cs;
        check("read_wrap", got, 32'h7E11);
        qspi_read(24'hFFC000, 2, got);
        finish_cs;
        check("read_alias", got, 32'h11);
        qspi_write(24'h000010, 20'h12345, 5);
        qspi_read(24'h000010, 6, got);
        finish_cs;
`ifdef QSPI_MEM_EMU_WRITE_EN
        check("write_readback", got, 32'h12345A);
`else
        check("rom_unchanged", got, 32'hC0DE5A);
`endif
        header(8'h9F, 24'h000000);
        for (int i = 0; i < 4; i++) nib(4'hA);
        finish_cs;
        qspi_read(24'h000000, 2, got);
        finish_cs;
        check("read_after_unknown", got, 32'h11);
        qspi_read(24'h000001, 3, got);
        finish_cs;
        check("cs_abort_partial", got, 32'h3C4);
        qspi_read(24'h000000, 4, got);
        finish_cs;
        check("read_after_abort", got, 32'h113C);
        qspi_read(24'h000000, 3, got);
        check("reset_abort_partial", got, 32'h113);
        reset_pulse;
        qspi_read(24'h000100, 2, got);
        finish_cs;
        check("backdoor_in_reset", got, 32'h9D);
        qspi_read(24'h000000, 4, got);
        finish_cs;
        check("mem_kept_after_reset", got, 32'h113C);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
